// File: rtl/in_unit_pkg.sv
// Shared types for the IN unit: ROB tag width, CDB payload and default buffer depth.
package in_unit_pkg;

    localparam int ROB_WIDTH    = 5;
    localparam int IN_BUF_DEPTH = 16;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    function automatic logic [31:0] zext_byte(input logic [7:0] b);
        return {24'b0, b};
    endfunction

endpackage

// File: rtl/req_if.sv
// Valid/ready handshake bundle; the handshake fires when both are high.
interface req_if;
    logic valid;
    logic ready;

    modport sink   (input valid, output ready);
    modport source (output valid, input ready);
endinterface

// File: rtl/in_byte_fifo.sv
// Receive byte FIFO with a speculative read pointer that can be rewound to the
// committed read pointer. Pointers carry one extra bit to tell full from empty.
module in_byte_fifo
    import in_unit_pkg::*;
#(
    parameter int DEPTH = IN_BUF_DEPTH,
    localparam int PW   = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       spec_pop,
    input  logic       commit_pop,
    input  logic       rewind,
    output logic [7:0] spec_data,
    output logic       spec_empty,
    output logic       full
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] spec_ptr;
    logic [PW-1:0] cmt_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-2:0]] <= push_data;
    end

    // A rewind lands on the committed position, including a commit in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            spec_ptr <= '0;
            cmt_ptr  <= '0;
        end else begin
            if (push)       wr_ptr  <= wr_ptr + PW'(1);
            if (commit_pop) cmt_ptr <= cmt_ptr + PW'(1);
            if (rewind)        spec_ptr <= cmt_ptr + PW'(commit_pop);
            else if (spec_pop) spec_ptr <= spec_ptr + PW'(1);
        end
    end

    assign spec_data  = mem[spec_ptr[PW-2:0]];
    assign spec_empty = (spec_ptr == wr_ptr);
    assign full       = ((wr_ptr - cmt_ptr) == PW'(DEPTH));

endmodule

// File: rtl/in_unit.sv
// IN instruction unit: serves received bytes to in-order IN instructions speculatively,
// consuming a byte only at commit. Optional sticky overrun flag under IN_OVERRUN_EN.
module in_unit
    import in_unit_pkg::*;
#(
    parameter int BUF_DEPTH = IN_BUF_DEPTH,
    parameter int N_ENTRY   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    req_if.sink                  issue_req,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    req_if.sink                  commit_req,
    input  logic                 receiver_valid,
    input  logic [7:0]           receiver_out,
    output logic                 cdb_req_valid,
    input  logic                 cdb_req_ready,
    output cdb_t                 cdb_out
`ifdef IN_OVERRUN_EN
    ,
    output logic                 overrun
`endif
);

    localparam int CW = $clog2(N_ENTRY + 1);
    localparam int IW = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;

    logic [ROB_WIDTH-1:0] entry_tag [N_ENTRY];
    logic [N_ENTRY-1:0]   entry_sent;
    logic [CW-1:0]        count;

    logic [ROB_WIDTH-1:0] n_tag [N_ENTRY];
    logic [N_ENTRY-1:0]   n_sent;
    logic [CW-1:0]        n_count;

    logic          cand_found;
    logic [IW-1:0] cand_idx;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] app_idx;
    logic          commit_ready, commit, issue_ready, issue_fire, grant;
    logic [7:0]    spec_data;
    logic          spec_empty, fifo_full;

    in_byte_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (receiver_valid && !fifo_full),
        .push_data  (receiver_out),
        .spec_pop   (grant && !flush),
        .commit_pop (commit),
        .rewind     (flush),
        .spec_data  (spec_data),
        .spec_empty (spec_empty),
        .full       (fifo_full)
    );

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = N_ENTRY - 1; i >= 0; i--) begin
            if (CW'(i) < count && !entry_sent[i]) begin
                cand_found = 1'b1;
                cand_idx   = IW'(i);
            end
        end
    end

    assign commit_ready     = (count != '0) && entry_sent[0];
    assign commit           = commit_req.valid && commit_ready;
    assign issue_ready      = (count < CW'(N_ENTRY)) || commit;
    assign issue_fire       = issue_req.valid && issue_ready;
    assign cdb_req_valid    = cand_found && !spec_empty;
    assign grant            = cdb_req_valid && cdb_req_ready;
    assign issue_req.ready  = issue_ready;
    assign commit_req.ready = commit_ready;

    assign cdb_out.valid = grant;
    assign cdb_out.tag   = entry_tag[cand_idx];
    assign cdb_out.data  = zext_byte(spec_data);

    // Grant and append indices refer to the queue after a same-cycle commit shift.
    assign grant_idx = cand_idx - IW'(commit);
    assign app_idx   = IW'(count - CW'(commit));

    always_comb begin
        for (int i = 0; i < N_ENTRY; i++) n_tag[i] = entry_tag[i];
        n_sent  = entry_sent;
        n_count = count;
        if (commit) begin
            for (int i = 0; i < N_ENTRY - 1; i++) begin
                n_tag[i]  = entry_tag[i+1];
                n_sent[i] = entry_sent[i+1];
            end
            n_sent[N_ENTRY-1] = 1'b0;
            n_count = count - CW'(1);
        end
        if (flush) begin
            n_sent  = '0;
            n_count = '0;
        end else begin
            if (grant) n_sent[grant_idx] = 1'b1;
            if (issue_fire) begin
                n_tag[app_idx]  = issue_tag;
                n_sent[app_idx] = 1'b0;
                n_count         = n_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            entry_sent <= '0;
            for (int i = 0; i < N_ENTRY; i++) entry_tag[i] <= '0;
        end else begin
            count      <= n_count;
            entry_sent <= n_sent;
            for (int i = 0; i < N_ENTRY; i++) entry_tag[i] <= n_tag[i];
            assert (!(commit_req.valid && !entry_sent[0]))
                else $error("in_unit: commit requested before head byte was broadcast");
        end
    end

`ifdef IN_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (receiver_valid && fifo_full) begin
            overrun <= 1'b1;
            $info("in_unit: receive byte 0x%02h dropped, buffer full", receiver_out);
        end
    end
`endif

endmodule

// File: tb/tb_in_unit.sv
// Directed self-checking bench for in_unit; covers the overrun flag when IN_OVERRUN_EN is set.
module tb_in_unit;
    import in_unit_pkg::*;

    logic                 clk;
    logic                 reset;
    logic                 flush;
    logic [ROB_WIDTH-1:0] issue_tag;
    logic                 receiver_valid;
    logic [7:0]           receiver_out;
    logic                 cdb_req_valid;
    logic                 cdb_req_ready;
    cdb_t                 cdb_out;
`ifdef IN_OVERRUN_EN
    logic                 overrun;
`endif

    req_if issue_req ();
    req_if commit_req ();

    int tests_run  = 0;
    int fail_count = 0;

    in_unit #(.BUF_DEPTH(16), .N_ENTRY(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .issue_req      (issue_req),
        .issue_tag      (issue_tag),
        .commit_req     (commit_req),
        .receiver_valid (receiver_valid),
        .receiver_out   (receiver_out),
        .cdb_req_valid  (cdb_req_valid),
        .cdb_req_ready  (cdb_req_ready),
        .cdb_out        (cdb_out)
`ifdef IN_OVERRUN_EN
        ,
        .overrun        (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv, input logic [7:0] rb, input logic iv,
                                 input logic [ROB_WIDTH-1:0] tag, input logic cv,
                                 input logic gr, input logic fl);
        receiver_valid   = rv;
        receiver_out     = rb;
        issue_req.valid  = iv;
        issue_tag        = tag;
        commit_req.valid = cv;
        cdb_req_ready    = gr;
        flush            = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
            else begin
                fail_count++;
                $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
            end
    endtask

    task automatic checkCdb(input string name, input logic [ROB_WIDTH-1:0] tag, input logic [7:0] b);
        checkOutput({name, ".req"},  32'(cdb_req_valid), 32'd1);
        checkOutput({name, ".tag"},  32'(cdb_out.tag),   32'(tag));
        checkOutput({name, ".data"}, cdb_out.data,       {24'b0, b});
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        tick;
        tick;
        checkOutput("rst.req_valid", 32'(cdb_req_valid), 32'd0);
        checkOutput("rst.cdb_valid", 32'(cdb_out.valid), 32'd0);
        checkOutput("rst.issue_rdy", 32'(issue_req.ready), 32'd1);
        checkOutput("rst.commit_rdy", 32'(commit_req.ready), 32'd0);
        checkOutput("rst.count", 32'(dut.count), 32'd0);
        reset = 1'b0;

        // Byte order and tags
        applyStimulus(1, 8'h41, 1, 5'd3, 0, 1, 0);
        tick;
        applyStimulus(1, 8'h42, 1, 5'd4, 0, 1, 0);
        checkCdb("order.t3", 5'd3, 8'h41);
        checkOutput("order.t3.valid", 32'(cdb_out.valid), 32'd1);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 1, 1, 0);
        checkOutput("order.commit_rdy1", 32'(commit_req.ready), 32'd1);
        checkCdb("order.t4", 5'd4, 8'h42);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 1, 1, 0);
        checkOutput("order.commit_rdy2", 32'(commit_req.ready), 32'd1);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        checkOutput("order.cmt_ptr", 32'(dut.u_fifo.cmt_ptr), 32'd2);
        checkOutput("order.count", 32'(dut.count), 32'd0);
        checkOutput("order.idle_req", 32'(cdb_req_valid), 32'd0);

        // Issue before data
        applyStimulus(0, 8'h00, 1, 5'd7, 0, 1, 0);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        checkOutput("early.req0", 32'(cdb_req_valid), 32'd0);
        tick;
        applyStimulus(1, 8'h5A, 0, 0, 0, 1, 0);
        checkOutput("early.req_t", 32'(cdb_req_valid), 32'd0);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        checkCdb("early.t1", 5'd7, 8'h5A);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 1, 1, 0);
        checkOutput("early.commit_rdy", 32'(commit_req.ready), 32'd1);
        tick;

        // Flush rewind
        applyStimulus(1, 8'h10, 1, 5'd1, 0, 1, 0);
        tick;
        applyStimulus(1, 8'h11, 1, 5'd2, 0, 1, 0);
        checkCdb("rew.b1", 5'd1, 8'h10);
        tick;
        applyStimulus(1, 8'h12, 1, 5'd3, 0, 1, 0);
        checkCdb("rew.b2", 5'd2, 8'h11);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        checkCdb("rew.b3", 5'd3, 8'h12);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 1, 1, 0);
        checkOutput("rew.commit_rdy", 32'(commit_req.ready), 32'd1);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 1);
        tick;
        applyStimulus(0, 8'h00, 1, 5'd9, 0, 1, 0);
        checkOutput("rew.count", 32'(dut.count), 32'd0);
        checkOutput("rew.spec_ptr", 32'(dut.u_fifo.spec_ptr), 32'd4);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        checkCdb("rew.t9", 5'd9, 8'h11);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 1, 1, 0);
        tick;

        // Full queue (0x12 still waits in the buffer)
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'h00, 1, 5'(10 + i), 0, 0, 0);
            tick;
        end
        applyStimulus(0, 8'h00, 1, 5'd20, 0, 0, 0);
        checkOutput("full.issue_rdy0", 32'(issue_req.ready), 32'd0);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        checkOutput("full.count4", 32'(dut.count), 32'd4);
        checkCdb("full.t10", 5'd10, 8'h12);
        tick;
        applyStimulus(0, 8'h00, 1, 5'd14, 1, 0, 0);
        checkOutput("full.issue_rdy_cmt", 32'(issue_req.ready), 32'd1);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("full.count_stay", 32'(dut.count), 32'd4);
        checkOutput("full.issue_rdy_again", 32'(issue_req.ready), 32'd0);
        checkOutput("full.tail_tag", 32'(dut.entry_tag[3]), 32'd14);
        checkOutput("full.head_tag", 32'(dut.entry_tag[0]), 32'd11);

        // Grant stall
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 1);
        tick;
        applyStimulus(1, 8'h77, 1, 5'd5, 0, 0, 0);
        tick;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 8'h00, 0, 0, 0, 0, 0);
            checkCdb("stall.hold", 5'd5, 8'h77);
            checkOutput("stall.spec_ptr", 32'(dut.u_fifo.spec_ptr), 32'd6);
            checkOutput("stall.no_valid", 32'(cdb_out.valid), 32'd0);
            tick;
        end
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        checkOutput("stall.grant_valid", 32'(cdb_out.valid), 32'd1);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        checkOutput("stall.spec_ptr_adv", 32'(dut.u_fifo.spec_ptr), 32'd7);
        checkOutput("stall.req_after", 32'(cdb_req_valid), 32'd0);
        applyStimulus(0, 8'h00, 0, 0, 1, 1, 0);
        checkOutput("stall.commit_rdy", 32'(commit_req.ready), 32'd1);
        tick;

        // Overflow: 17 bytes into a 16-deep buffer
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 8'(8'h80 + i), 0, 0, 0, 0, 0);
`ifdef IN_OVERRUN_EN
            checkOutput("ovr.flag_clear", 32'(overrun), 32'd0);
`endif
            tick;
        end
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("ovr.wr_ptr", 32'(dut.u_fifo.wr_ptr), 32'd23);
`ifdef IN_OVERRUN_EN
        checkOutput("ovr.flag_set", 32'(overrun), 32'd1);
`endif
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 8'h00, 1, 5'(16 + i), 0, 0, 0);
            tick;
            applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
            checkCdb("ovr.deliver", 5'(16 + i), 8'(8'h80 + i));
            tick;
            applyStimulus(0, 8'h00, 0, 0, 1, 0, 0);
            tick;
        end
        applyStimulus(0, 8'h00, 1, 5'd2, 0, 1, 0);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        checkOutput("ovr.dropped_absent", 32'(cdb_req_valid), 32'd0);
`ifdef IN_OVERRUN_EN
        checkOutput("ovr.flag_sticky", 32'(overrun), 32'd1);
`endif
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 1);
        tick;
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/in_unit.md
Name: in_unit

Overview:
- Input-side counterpart of the UART output path.
- Buffers bytes arriving from the UART receiver and serves IN instructions in program order.
- Each IN instruction is allocated a ROB tag at issue. The unit broadcasts `{24'b0, byte}` on the CDB speculatively, and a byte is consumed permanently only when its instruction commits.
- A pipeline flush rewinds the speculative read position, so no received byte is lost to misprediction.

Parameters:
- BUF_DEPTH, 16, receive byte FIFO depth (power of two, ≥2)
- N_ENTRY, 4, in-flight IN instructions tracked (issued, not committed)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high; full reset of all state
- flush  input  1  pipeline flush (mispredict); discards uncommitted IN instructions
- issue_req  req_if  -  valid from dispatcher, ready driven here; handshake = valid && ready
- issue_tag  input  ROB_WIDTH  ROB tag of the issuing IN instruction
- commit_req  req_if  -  valid from ROB when the head IN commits, ready driven here
- receiver_valid  input  1  one-cycle pulse, byte received
- receiver_out  input  8  received byte
- cdb_req_valid  output  1  request to broadcast
- cdb_req_ready  input  1  CDB grant, same cycle
- cdb_out  output  cdb_t  valid/tag/data; `data = {24'b0, byte}`

Behaviour:
- State:
  - FIFO storage `buf[BUF_DEPTH]`.
  - Pointers `wr_ptr`, `spec_ptr`, `cmt_ptr`, each `$clog2(BUF_DEPTH)+1` bits, wrapping modulo `2*BUF_DEPTH`.
  - Pending queue `entry[N_ENTRY]` of {tag, sent}, head at index 0, plus `count`.
- Reset:
  - All pointers and `count` go to 0; all `sent` bits clear.
  - `cdb_req_valid=0`, `cdb_out.valid=0`.
  - `issue_req.ready=1` and `commit_req.ready=0` after reset.
- Receive:
  - FIFO full when `wr_ptr - cmt_ptr == BUF_DEPTH`.
  - If `receiver_valid` and not full: write `buf[wr_ptr]`, then `wr_ptr++`.
  - If full: the byte is dropped.
  - A written byte is first eligible for broadcast on the next cycle.
  - Writing continues during flush.
- Issue:
  - `issue_req.ready = (count < N_ENTRY) || commit`.
  - On handshake, append {`issue_tag`, sent=0} at index `count - commit`.
  - A newly issued entry is not eligible for broadcast in its issue cycle.
- Broadcast:
  - Candidate = lowest-index entry with `sent=0`.
  - `cdb_req_valid = candidate exists && spec_ptr != wr_ptr`.
  - `cdb_out.tag` = candidate tag; `cdb_out.data = {24'b0, buf[spec_ptr]}`.
  - `cdb_out.valid = cdb_req_valid && cdb_req_ready`.
  - On grant: set the candidate's `sent`, and `spec_ptr++`.
  - At most one broadcast per cycle.
- Commit:
  - `commit_req.ready = count > 0 && entry[0].sent`.
  - On commit: shift the queue down by one, `cmt_ptr++`, `count--`.
  - If `commit_req.valid && !entry[0].sent`: simulation `$display` error; state unchanged.
- Simultaneous events:
  - Commit, issue, grant and receive may all occur in one cycle and are applied together.
  - Grant index and issue append index are computed post-shift.
- Flush:
  - `count ← 0`; all `sent` bits clear; `spec_ptr ← cmt_ptr + commit`. A commit in the same cycle is honoured.
  - Issue and grant in the flush cycle are discarded.
  - `wr_ptr` is unaffected.
- reset has priority over flush.

Optional Feature:
- Macro: IN_OVERRUN_EN.
- When defined:
  - Adds output `overrun` (1 bit), sticky.
  - Set the cycle after a byte is dropped because the FIFO is full.
  - Cleared only by reset.
  - Adds a simulation `$display` on each drop.
- When undefined: the port is absent and drops are silent.

Decomposition:
- `ROB_WIDTH`, `cdb_t` and `req_if` stay in `common.vh`; add `IN_BUF_DEPTH` there.
- Sub-module `in_byte_fifo`:
  - Holds the storage and the three pointers.
  - Interface: push, spec_pop, commit_pop, rewind.
  - Outputs: spec_data, spec_empty, full.
- `in_unit` holds the pending tag queue, handshakes and CDB logic.

Test Plan:
- Byte order and tags: receive 0x41, 0x42; issue tags 3, 4; grant every cycle.
  - Expect CDB {tag3, 0x41}, then {tag4, 0x42}.
  - Commit both; `cmt_ptr` reaches 2.
- Issue before data: issue tag 7 with FIFO empty.
  - `cdb_req_valid` stays 0.
  - Receive 0x5A at cycle t; `cdb_req_valid=1` at t+1 with {7, 0x5A}.
- Flush rewind: receive 0x10, 0x11, 0x12; issue tags 1, 2, 3; broadcast all three; commit tag 1; flush.
  - Issue tag 9; expect broadcast {9, 0x11}.
- Full queue: issue N_ENTRY=4 tags; `issue_req.ready` drops to 0.
  - Commit in the same cycle as a fifth issue; that issue is accepted and `count` stays 4.
- Grant stall: hold `cdb_req_ready=0` for 5 cycles.
  - Request and tag/data stay stable.
  - Grant on cycle 6; `spec_ptr` advances by exactly 1.
- Overrun (IN_OVERRUN_EN): push 17 bytes with no commits.
  - The 17th byte is dropped and `overrun=1` the next cycle.
  - The first 16 bytes are delivered intact.
